// File: rtl/adc_stream_pkg.sv
// Shared types and defaults for the ADC stream ingest blocks.
package adc_stream_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer between a valid/ready sink and a FIFO write port.
// ready_o is a flop; write strobe and data are combinational from the held entries.
module axis_skid_buf
    import adc_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              full_i,
    output logic              ready_o,
    output logic              accept_o,
    output logic              wr_en_o,
    output logic [DATA_W-1:0] wr_data_o
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] ent0_q, ent0_d;
    logic [DATA_W-1:0] ent1_q, ent1_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              write;

    assign accept = valid_i & ready_q;
    assign write  = enable_i & (state_q != EMPTY) & ~full_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a simultaneous accept and write leaves occupancy unchanged.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !write) begin
                        state_d = TWO;
                    end else if (!accept && write) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (write) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        accept_o  = accept;
        wr_en_o   = write;
        wr_data_o = ent0_q;
        ready_o   = ready_q;
    end

    // Entry 0 always holds the oldest beat; entry 1 only fills from ONE.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case (state_q)
            EMPTY: if (accept) ent0_d = data_i;
            ONE: begin
                if (accept) begin
                    if (write) begin
                        ent0_d = data_i;
                    end else begin
                        ent1_d = data_i;
                    end
                end
            end
            TWO:     if (write) ent0_d = ent1_q;
            default: ent0_d = ent0_q;
        endcase
        ready_d = enable_i & (state_d != TWO);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/axis_stream_in.sv
// AXI-Stream style sink feeding a FIFO through a skid buffer, with an
// accepted-beat counter and a sticky handshake-violation checker.
module axis_stream_in
    import adc_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              proto_err,
    input  logic              clr
);

    logic              accept;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] prev_data_q, prev_data_d;
    logic              err_q, err_d;
    logic              violation;

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .enable_i  (enable),
        .valid_i   (s_valid),
        .data_i    (s_data),
        .full_i    (fifo_full),
        .ready_o   (s_ready),
        .accept_o  (accept),
        .wr_en_o   (fifo_wr_en),
        .wr_data_o (fifo_wr_data)
    );

    // A stalled beat must stay valid with stable data until it is taken.
    assign violation = pend_q & (~s_valid | (s_data != prev_data_q)) & enable;

    always_comb begin
        cnt_d       = cnt_q;
        err_d       = err_q;
        pend_d      = s_valid & ~s_ready;
        prev_data_d = s_data;
        if (clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (violation) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q       <= '0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            prev_data_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            prev_data_q <= prev_data_d;
        end
    end

    assign beat_cnt  = cnt_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_axis_stream_in.sv
// Directed and randomized bench for axis_stream_in against a queue-based model.
module tb_axis_stream_in;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MOD = 16;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              enable;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_full;
    logic [CNT_W-1:0]  beat_cnt;
    logic              proto_err;
    logic              clr;

    axis_stream_in #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .beat_cnt     (beat_cnt),
        .proto_err    (proto_err),
        .clr          (clr)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: buffered beats as a FIFO queue plus handshake bookkeeping.
    logic [DATA_W-1:0] mq[$];
    bit                m_ready;
    int                m_cnt;
    bit                m_err;
    bit                m_pend;
    logic [DATA_W-1:0] m_pdata;

    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] wr_log[$];
    logic [DATA_W-1:0] acc_log[$];
    bit                manual = 1'b0;
    bit                gaps = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready = 1'b0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
        m_pdata = '0;
    endtask

    // Source obeys the handshake: a stalled valid beat is held unchanged.
    task automatic src_drive(input bit acc);
        if (acc && src_q.size() > 0) void'(src_q.pop_front());
        if (!(s_valid && !acc)) begin
            if (src_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = src_q[0];
            end else begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model across the edge.
    task automatic cycle();
        bit acc;
        bit exp_wr;
        bit set_err;
        @(negedge sys_clk);
        exp_wr = enable && mq.size() > 0 && !fifo_full;
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
        if (exp_wr) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(mq[0]));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        chk("proto_err", 32'(proto_err), 32'(m_err));
        if (fifo_wr_en) wr_log.push_back(fifo_wr_data);
        acc     = s_valid && m_ready;
        set_err = m_pend && (!s_valid || s_data != m_pdata) && enable;
        if (acc) acc_log.push_back(s_data);
        if (exp_wr) void'(mq.pop_front());
        if (acc) mq.push_back(s_data);
        if (!enable) mq.delete();
        if (clr) begin
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            if (acc) m_cnt = (m_cnt + 1) % CNT_MOD;
            if (set_err) m_err = 1'b1;
        end
        m_pend  = s_valid && !m_ready;
        m_pdata = s_data;
        m_ready = enable && mq.size() < 2;
        @(posedge sys_clk);
        #1;
        if (!manual) src_drive(acc);
    endtask

    initial begin
        sys_rst   = 1'b1;
        enable    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        fifo_full = 1'b0;
        clr       = 1'b0;
        model_reset();

        // Reset values held while reset is asserted
        #12;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_wr_data", 32'(fifo_wr_data), 0);
        chk("rst_cnt", 32'(beat_cnt), 0);
        chk("rst_err", 32'(proto_err), 0);
        @(posedge sys_clk);
        #2;
        enable  = 1'b1;
        sys_rst = 1'b0;
        cycle();

        // Back-to-back streaming
        wr_log.delete();
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        src_drive(1'b0);
        repeat (11) cycle();
        chk("stream_nwr", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) chk("stream_order", 32'(wr_log[i]), i + 1);
        chk("stream_cnt", 32'(beat_cnt), 8);

        // Backpressure
        fifo_full = 1'b1;
        wr_log.delete();
        src_q.push_back(16'hA5A5);
        src_q.push_back(16'h5A5A);
        src_drive(1'b0);
        repeat (3) cycle();
        chk("bp_ready_low", 32'(s_ready), 0);
        chk("bp_no_write", wr_log.size(), 0);
        fifo_full = 1'b0;
        repeat (3) cycle();
        chk("bp_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("bp_first", 32'(wr_log[0]), 32'h0000_A5A5);
            chk("bp_second", 32'(wr_log[1]), 32'h0000_5A5A);
        end
        chk("bp_ready_high", 32'(s_ready), 1);

        // Flush on enable low
        fifo_full = 1'b1;
        src_q.push_back(16'h1111);
        src_q.push_back(16'h2222);
        src_drive(1'b0);
        repeat (3) cycle();
        enable = 1'b0;
        cycle();
        enable    = 1'b1;
        fifo_full = 1'b0;
        wr_log.delete();
        repeat (4) cycle();
        chk("flush_no_write", wr_log.size(), 0);
        chk("flush_ready", 32'(s_ready), 1);

        // Protocol violation: data changes while stalled
        fifo_full = 1'b1;
        src_q.push_back(16'h0AAA);
        src_q.push_back(16'h0BBB);
        src_drive(1'b0);
        repeat (3) cycle();
        manual  = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        cycle();
        chk("proto_quiet", 32'(proto_err), 0);
        s_data = 16'h4321;
        cycle();
        chk("proto_set", 32'(proto_err), 1);
        s_valid = 1'b0;
        repeat (3) cycle();
        chk("proto_sticky", 32'(proto_err), 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("proto_clr", 32'(proto_err), 0);
        fifo_full = 1'b0;
        manual    = 1'b0;
        repeat (3) cycle();

        // Counter wrap and clear-vs-accept priority
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 17; i++) src_q.push_back(16'(16'h0100 + i));
        src_drive(1'b0);
        repeat (22) cycle();
        chk("wrap_cnt", 32'(beat_cnt), 1);
        src_q.push_back(16'h0777);
        src_drive(1'b0);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr_over_acc", 32'(beat_cnt), 0);
        repeat (3) cycle();

        // Randomized traffic with stalls and occasional clear
        wr_log.delete();
        acc_log.delete();
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 50) == 0);
            if (src_q.size() < 3 && $urandom_range(0, 3) != 0) src_q.push_back(16'($urandom));
            cycle();
        end
        fifo_full = 1'b0;
        clr       = 1'b0;
        gaps      = 1'b0;
        repeat (12) cycle();
        chk("rand_nwr", wr_log.size(), acc_log.size());
        for (int i = 0; i < wr_log.size() && i < acc_log.size(); i++)
            chk("rand_order", 32'(wr_log[i]), 32'(acc_log[i]));

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) src_q.push_back(16'(16'hC000 + i));
        src_drive(1'b0);
        repeat (3) cycle();
        #3;
        sys_rst = 1'b1;
        #1;
        chk("arst_ready", 32'(s_ready), 0);
        chk("arst_wr_en", 32'(fifo_wr_en), 0);
        chk("arst_wr_data", 32'(fifo_wr_data), 0);
        chk("arst_cnt", 32'(beat_cnt), 0);
        chk("arst_err", 32'(proto_err), 0);
        @(posedge sys_clk);
        @(posedge sys_clk);
        #2;
        src_q.delete();
        s_valid = 1'b0;
        model_reset();
        sys_rst = 1'b0;
        cycle();
        chk("arst_ready_rise", 32'(s_ready), 1);
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_stream_in.md
AXIS_STREAM_IN -- requirements
Module: axis_stream_in

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width.
REQ-002 SHALL have parameter CNT_W, default 32, beat-counter width.
REQ-003 SHALL have port sys_clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  in  1  sink enable; low = flush and refuse input.
REQ-006 SHALL have port s_valid  in  1  upstream beat valid.
REQ-007 SHALL have port s_ready  out  1  sink ready, driven directly from a flop.
REQ-008 SHALL have port s_data  in  DATA_W  upstream beat data.
REQ-009 SHALL have port fifo_wr_en  out  1  FIFO write strobe, sys_clk domain.
REQ-010 SHALL have port fifo_wr_data  out  DATA_W  FIFO write data.
REQ-011 SHALL have port fifo_full  in  1  FIFO full; no write issued while high.
REQ-012 SHALL have port beat_cnt  out  CNT_W  count of accepted beats, wraps.
REQ-013 SHALL have port proto_err  out  1  sticky handshake-violation flag.
REQ-014 SHALL have port clr  in  1  synchronous clear of beat_cnt and proto_err.

Function
REQ-015 SHALL accept a beat on a cycle where s_valid and s_ready are both high.
REQ-016 SHALL buffer accepted beats in a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-017 SHALL drive s_ready high next cycle iff enable is high and the next state is not TWO.
REQ-018 SHALL assert fifo_wr_en combinationally iff the buffer is not EMPTY and fifo_full is low, with fifo_wr_data equal to the oldest entry.
REQ-019 SHALL give a latency of 1 cycle: a beat accepted at edge N is presented on fifo_wr_en/fifo_wr_data after edge N.
REQ-020 SHALL handle accept and write on the same edge as follows: state unchanged, FIFO order preserved.
REQ-021 SHALL apply these transitions: EMPTY→ONE on accept; ONE→TWO on accept without write; ONE→EMPTY on write without accept; TWO→ONE on write.
REQ-022 SHALL give a throughput of 1 beat/cycle when fifo_full stays low.
REQ-023 SHALL, when fifo_full is high, hold the buffer contents; no beat SHALL ever be lost or duplicated.
REQ-024 SHALL, when enable is low, force the buffer to EMPTY on the next edge, drive s_ready low and keep fifo_wr_en low; in-flight entries are discarded.
REQ-025 SHALL increment beat_cnt by 1 per accepted beat, modulo 2^CNT_W.
REQ-026 SHALL set proto_err when s_valid was high and s_ready low on the previous cycle, and on this cycle s_valid is low or s_data has changed, while enable is high.
REQ-027 SHALL give clr priority over increment and set on the same edge.

Reset
REQ-028 SHALL, while sys_rst is high, hold s_ready=0, fifo_wr_en=0, fifo_wr_data=0, beat_cnt=0, proto_err=0 and the state at EMPTY.
REQ-029 SHALL, on reset mid-transfer, discard buffered beats; s_ready rises on the first edge after release when enable is high.

Structure
REQ-030 SHALL place the state enum (EMPTY/ONE/TWO) and the DATA_W default in shared package adc_stream_pkg, reused by the stream blocks.
REQ-031 SHALL implement the skid buffer as sub-module axis_skid_buf, with the counter and checker kept in the top.

Verification
REQ-032 SHALL verify streaming: enable=1, fifo_full=0, 8 beats 0x0001..0x0008 back-to-back → 8 writes in order, 1-cycle latency, beat_cnt=8.
REQ-033 SHALL verify backpressure: fifo_full=1 after 2 accepted beats (0xA5A5, 0x5A5A) → s_ready=0 next cycle, no writes; release fifo_full → writes 0xA5A5 then 0x5A5A, s_ready=1.
REQ-034 SHALL verify flush: 2 beats buffered with fifo_full=1, then enable=0 for 1 cycle → state EMPTY, nothing written after re-enable.
REQ-035 SHALL verify the protocol check: s_valid=1 with s_data=0x1234 while s_ready=0, then s_data=0x4321 → proto_err=1 and stays 1 until clr.
REQ-036 SHALL verify counter wrap: CNT_W=4, 17 beats → beat_cnt=1; clr together with an accept → beat_cnt=0.
REQ-037 SHALL verify async reset: assert sys_rst mid-burst between edges → all outputs reach reset values immediately, without a clock edge.
